// File: rtl/nibble_add_sequencer.sv
// Shares one 4-bit add slice between two round-robin requesters, adding WORDS nibbles serially.
// Grant at edge k, done pulse after edge k+WORDS; requests are only sampled in IDLE.
module nibble_add_sequencer #(
  parameter  int WORDS = 4,
  localparam int W     = 4 * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic            carry;
  logic            last;
  logic            owner;
  logic [IDXW-1:0] idx;

  logic            take;
  logic            winner;
  logic            last_nib;
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      nib_s;
  logic            nib_c;

  // Round-robin: a lone requester wins outright; on a tie the one that did not win last time.
  always_comb begin
    take   = 1'b0;
    winner = 1'b0;
    if (state == IDLE) begin
      if (req0 && req1) begin
        take   = 1'b1;
        winner = ~last;
      end else if (req0) begin
        take   = 1'b1;
        winner = 1'b0;
      end else if (req1) begin
        take   = 1'b1;
        winner = 1'b1;
      end
    end
  end

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IDXW'(i)) begin
        nib_a = opa[4*i +: 4];
        nib_b = opb[4*i +: 4];
      end
    end
  end

  // The shared 4-bit slice: A + B + Cin -> {Cout, S}.
  assign {nib_c, nib_s} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
  assign last_nib       = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (take) begin
            opa   <= winner ? a1 : a0;
            opb   <= winner ? b1 : b0;
            carry <= winner ? cin1 : cin0;
            idx   <= '0;
            last  <= winner;
            owner <= winner;
            gnt0  <= ~winner;
            gnt1  <= winner;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IDXW'(i)) sum[4*i +: 4] <= nib_s;
          end
          carry <= nib_c;
          if (last_nib) begin
            cout    <= nib_c;
            done    <= 1'b1;
            done_id <= owner;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_done_no_gnt: assert property (@(posedge clk) disable iff (rst) !(done && (gnt0 || gnt1)));

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Scoreboard bench: a cycle-count model predicts grants/done, a queue holds expected results.
module tb_nibble_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic         cin0 = 1'b0;
  logic         cin1 = 1'b0;
  logic [W-1:0] a0   = '0;
  logic [W-1:0] b0   = '0;
  logic [W-1:0] a1   = '0;
  logic [W-1:0] b1   = '0;
  logic         gnt0, gnt1, busy, done, done_id, cout;
  logic [W-1:0] sum;

  logic         s_req = 1'b0;
  logic         s_cin = 1'b0;
  logic [3:0]   s_a   = '0;
  logic [3:0]   s_b   = '0;
  logic         s_gnt0, s_gnt1, s_busy, s_done, s_done_id, s_cout;
  logic [3:0]   s_sum;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nibble_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
    .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .cout(cout)
  );

  nibble_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(s_req), .a0(s_a), .b0(s_b), .cin0(s_cin),
    .req1(1'b0), .a1(4'h0), .b1(4'h0), .cin1(1'b0),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .busy(s_busy), .done(s_done),
    .done_id(s_done_id), .sum(s_sum), .cout(s_cout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: whole transactions, a countdown for occupancy, plain addition for the result.
  typedef struct packed {
    logic         id;
    logic         co;
    logic [W-1:0] s;
  } res_t;

  res_t exp_q[$];
  int   m_cnt    = 0;
  logic m_last   = 1'b1;
  logic exp_gnt0 = 1'b0;
  logic exp_gnt1 = 1'b0;
  logic exp_done = 1'b0;
  logic exp_busy = 1'b0;

  always @(posedge clk) begin
    logic     w;
    logic [W:0] full;
    exp_gnt0 = 1'b0;
    exp_gnt1 = 1'b0;
    exp_done = 1'b0;
    if (rst) begin
      m_cnt  = 0;
      m_last = 1'b1;
      exp_q.delete();
    end else if (m_cnt == 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? !m_last : req1;
        if (w) full = {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, cin1};
        else   full = {1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, cin0};
        exp_q.push_back('{id: w, co: full[W], s: full[W-1:0]});
        m_last   = w;
        exp_gnt0 = !w;
        exp_gnt1 = w;
        m_cnt    = WORDS + 1;
      end
    end else begin
      m_cnt    = m_cnt - 1;
      exp_done = (m_cnt == 1);
    end
    exp_busy = (m_cnt != 0);
  end

  always @(negedge clk) begin
    res_t e;
    if (gnt0 || exp_gnt0) chk("gnt0", 64'(gnt0), 64'(exp_gnt0));
    if (gnt1 || exp_gnt1) chk("gnt1", 64'(gnt1), 64'(exp_gnt1));
    if (done || exp_done) chk("done", 64'(done), 64'(exp_done));
    chk("busy", 64'(busy), 64'(exp_busy));
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL result: done with {id,cout,sum}=0x%0h but nothing outstanding",
                 {done_id, cout, sum});
      end else begin
        e = exp_q.pop_front();
        chk("result{id,cout,sum}", 64'({done_id, cout, sum}), 64'(e));
      end
    end
  end

  task automatic issue(input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    logic g;
    if (which) begin a1 = a; b1 = b; cin1 = c; req1 = 1'b1; end
    else       begin a0 = a; b0 = b; cin0 = c; req0 = 1'b1; end
    g = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      g = which ? gnt1 : gnt0;
      if (g) break;
    end
    chk(which ? "gnt1_wait" : "gnt0_wait", 64'(g), 64'd1);
    if (which) req1 = 1'b0;
    else       req0 = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s_full;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gnt", 64'({gnt0, gnt1}), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);

    // Single-nibble instance
    s_a = 4'h9; s_b = 4'h8; s_cin = 1'b1; s_req = 1'b1;
    s_full = {1'b0, s_a} + {1'b0, s_b} + {4'b0000, s_cin};
    @(negedge clk);
    chk("w1_gnt0", 64'(s_gnt0), 64'd1);
    chk("w1_no_early_done", 64'(s_done), 64'd0);
    s_req = 1'b0;
    @(negedge clk);
    chk("w1_done", 64'(s_done), 64'd1);
    chk("w1_sum", 64'(s_sum), 64'(s_full[3:0]));
    chk("w1_cout", 64'(s_cout), 64'(s_full[4]));
    chk("w1_done_id", 64'(s_done_id), 64'd0);
    @(negedge clk);
    chk("w1_done_pulse_end", 64'(s_done), 64'd0);
    chk("w1_idle", 64'(s_busy), 64'd0);

    issue(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    repeat (WORDS + 3) @(negedge clk);
    issue(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    repeat (WORDS + 3) @(negedge clk);

    // Both requesters held high: grants alternate, spaced WORDS+2 apart.
    pulse_reset();
    a0 = 16'h8000; b0 = 16'h8000; cin0 = 1'b0;
    a1 = 16'h1357; b1 = 16'h2468; cin1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    repeat (4 * (WORDS + 2)) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (WORDS + 3) @(negedge clk);

    // Abort in the second RUN cycle.
    issue(1'b0, 16'hABCD, 16'h1111, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (WORDS + 2) @(negedge clk);
    issue(1'b0, 16'h0F0F, 16'hF0F1, 1'b0);
    repeat (WORDS + 3) @(negedge clk);

    // Operand and req1 churn while a req0 operation is running.
    issue(1'b0, 16'h4321, 16'h5678, 1'b1);
    for (int i = 0; i < WORDS - 1; i++) begin
      @(negedge clk);
      req1 = ~req1;
      a0   = 16'($urandom);
      b0   = 16'($urandom);
      a1   = 16'($urandom);
    end
    @(negedge clk);
    issue(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    repeat (WORDS + 3) @(negedge clk);

    // Random traffic.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (req0 && gnt0) begin
        req0 = 1'b0;
        a0   = 16'($urandom);
        b0   = 16'($urandom);
      end else if (!req0 && $urandom_range(0, 3) == 0) begin
        a0   = 16'($urandom);
        b0   = 16'($urandom);
        cin0 = 1'($urandom);
        req0 = 1'b1;
      end
      if (req1 && gnt1) begin
        req1 = 1'b0;
        a1   = 16'($urandom);
        b1   = 16'($urandom);
      end else if (!req1 && $urandom_range(0, 3) == 0) begin
        a1   = 16'($urandom);
        b1   = 16'($urandom);
        cin1 = 1'($urandom);
        req1 = 1'b1;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2 * (WORDS + 3)) @(negedge clk);
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_add_sequencer.md
Name: nibble_add_sequencer

Overview:
- Shares one 4-bit add slice (combinational A+B+Cin -> S, Cout) between two requesters.
- Adds wide operands nibble by nibble, propagating the carry through a register.
- Arbitrates between the two requesters round-robin, sequences the slice through WORDS nibbles, and returns a registered result with a one-cycle done pulse.
- Sits between lab-level control logic and the existing 4-bit ripple-adder datapath.

Parameters:
- WORDS, 4, nibbles per operand. Operand width W = 4*WORDS. Legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0  in  1  requester 0 request (level)
- a0  in  W  requester 0 operand A
- b0  in  W  requester 0 operand B
- cin0  in  1  requester 0 carry-in
- req1  in  1  requester 1 request (level)
- a1  in  W  requester 1 operand A
- b1  in  W  requester 1 operand B
- cin1  in  1  requester 1 carry-in
- gnt0  out  1  one-cycle pulse: requester 0 operands captured
- gnt1  out  1  one-cycle pulse: requester 1 operands captured
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse: sum/cout/done_id valid
- done_id  out  1  requester that owns the result
- sum  out  W  result, (A+B+Cin) mod 2^W
- cout  out  1  carry out of the top nibble

Behaviour:
- Reset: one cycle of rst at a clock edge sets the following, with priority over all other activity:
  - state=IDLE
  - gnt0=gnt1=done=busy=0
  - sum=0, cout=0, done_id=0
  - nibble index=0, carry register=0
  - round-robin pointer last=1, so requester 0 wins the first tie
- All outputs are registered. No combinational path from any input to any output.
- State IDLE: at edge k, if req0|req1:
  - Winner: the only requester asserting. If both assert, the requester != last.
  - Latch the winner's a, b, cin. Set last=winner, owner=winner.
  - Pulse gnt<winner>=1 for cycle k..k+1.
  - Set idx=0, carry=cin. State->RUN.
  - With no request, stay in IDLE.
- State RUN: at each edge:
  - The slice adds A[4*idx+:4] + B[4*idx+:4] + carry.
  - The result nibble is written to sum[4*idx+:4]. carry <= slice Cout.
  - If idx==WORDS-1: cout <= slice Cout, done <= 1, done_id <= owner, state->DONE.
  - Otherwise idx++.
- State DONE: done high for exactly this cycle. Next edge: done=0, state->IDLE. Requests are not sampled in DONE.
- Latency: grant at edge k, done visible after edge k+WORDS. Minimum grant-to-grant spacing is WORDS+2 cycles.
- sum, cout and done_id hold their values until the next done. Sum nibbles update progressively during RUN; consumers sample only on done.
- Requesters hold req and operands stable until they see gnt, then deassert req within one cycle. If req is still high in the IDLE following its own done, that is a new request.
- Requests and operand changes during RUN/DONE are ignored. The captured operands are unaffected.
- rst during RUN or DONE aborts the operation: no done pulse is issued, and the partial sum is cleared.
- gnt0 and gnt1 are never high together. done never coincides with a gnt.

Test Plan:
- WORDS=4; req0, a0=0x1234, b0=0x0FFF, cin0=0 -> gnt0 one cycle; done 4 cycles later; sum=0x2233, cout=0, done_id=0.
- Carry chain across all nibbles: req1, a1=0xFFFF, b1=0x0000, cin1=1 -> sum=0x0000, cout=1, done_id=1.
- After reset, req0 and req1 both held high continuously:
  - Grant order is 0,1,0,1.
  - Grants are spaced 6 cycles apart.
  - Each done_id matches its grant.
  - Results are correct for distinct operands, e.g. 0x8000+0x8000 -> 0x0000, cout=1.
- rst asserted in the 2nd RUN cycle -> no done pulse; sum=0, busy=0 next cycle; a following req0 is granted normally.
- Operands and req1 toggled during RUN of a req0 operation -> result uses the captured req0 operands; req1 is granted only after DONE->IDLE.
- WORDS=1: a=0x9, b=0x8, cin=1 -> sum=0x2, cout=1; done one cycle after grant.
